mem_backend: RTL and testbench

- Backing-store stage directly below the direct-mapped cache: 32 x 32-bit word memory with fixed, parameterised access latency and a req/ready/done handshake.
- The cache issues a single-word read on a miss and writes on every store (write-through).
- Models a slow main memory so that the cache's refill and stall paths are exercised cycle-accurately.

---
 rtl/mem_backend.sv | 126 ++++++++++++
 tb/tb_mem_backend.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_backend.sv
// Fixed-latency word memory behind the cache: one transaction in flight, req/ready/done handshake.
// Define MEM_BACKEND_STATS_EN to add saturating read/write completion counters (rd_cnt, wr_cnt).
module mem_backend #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
`ifdef MEM_BACKEND_STATS_EN
    ,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                ready_d, done_d;
    logic                accept, complete;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                ready_d = 1'b1;
                if (req && ready) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    ready_d = 1'b0;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            rdata   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            ready <= ready_d;
            done  <= done_d;
            if (accept) begin
                wr_q    <= wr;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (complete && !wr_q) begin
                rdata <= mem[addr_q];
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive rst, and an aborted write never reaches it.
    always_ff @(posedge clk) begin
        if (complete && wr_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign busy = ~ready;

`ifdef MEM_BACKEND_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (complete) begin
            if (wr_q && wr_cnt != 16'hFFFF) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (!wr_q && rd_cnt != 16'hFFFF) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_backend.sv
// Directed bench for mem_backend at LATENCY=4: handshake timing, data, back-to-back, ignore and abort.
module tb_mem_backend;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          done;
    logic [DW-1:0] rdata;
    logic          busy;
`ifdef MEM_BACKEND_STATS_EN
    logic [15:0]   rd_cnt;
    logic [15:0]   wr_cnt;
`endif

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint acc_cyc = 0;
    longint done_cyc = 0;

    mem_backend #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready),
        .done  (done),
        .rdata (rdata),
        .busy  (busy)
`ifdef MEM_BACKEND_STATS_EN
        ,
        .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge with ready=1; the request is accepted at the next rising edge.
    task automatic start_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        acc_cyc = cyc;
        checks++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: ready=%b busy=%b, expected ready=0 busy=1", ready, busy);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, expected 1", name, done, n);
        end
        checks++;
        if (done_cyc - acc_cyc != LAT) begin
            errors++;
            $display("FAIL %s_latency: %0d cycles, expected %0d", name, done_cyc - acc_cyc, LAT);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_with_done: ready=%b, expected 1", name, ready);
        end
    endtask

    task automatic check_rdata(input string name, input logic [DW-1:0] exp);
        checks++;
        if (rdata !== exp) begin
            errors++;
            $display("FAIL %s_rdata: got %h, expected %h", name, rdata, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b rdata=%h, expected 1 0 0 0",
                     ready, busy, done, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        start_txn(1'b1, 5'd5, 32'hDEADBEEF);
        wait_done("wr5");
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_pulse: done=%b one cycle later, expected 0", done);
        end
        start_txn(1'b0, 5'd5, '0);
        wait_done("rd5");
        check_rdata("rd5", 32'hDEADBEEF);
        start_txn(1'b1, 5'd6, 32'h12345678);
        wait_done("wr6");
        check_rdata("wr_keeps", 32'hDEADBEEF);
        start_txn(1'b0, 5'd6, '0);
        wait_done("rd6");
        check_rdata("rd6", 32'h12345678);
        @(negedge clk);
        @(negedge clk);
        check_rdata("idle_hold", 32'h12345678);
    endtask

    // Each request is presented while the previous done is high, so completions are LAT+1 edges apart.
    task automatic test_back_to_back();
        longint prev;
        for (int i = 0; i < 32; i++) begin
            start_txn(1'b1, AW'(i), DW'(i * 3));
            wait_done("b2b_wr");
            if (i > 0) begin
                checks++;
                if (done_cyc - prev != LAT + 1) begin
                    errors++;
                    $display("FAIL b2b_wr_gap: %0d cycles, expected %0d", done_cyc - prev, LAT + 1);
                end
            end
            prev = done_cyc;
        end
        for (int i = 0; i < 32; i++) begin
            start_txn(1'b0, AW'(i), '0);
            wait_done("b2b_rd");
            check_rdata("b2b_rd", DW'(i * 3));
            checks++;
            if (done_cyc - prev != LAT + 1) begin
                errors++;
                $display("FAIL b2b_rd_gap: %0d cycles, expected %0d", done_cyc - prev, LAT + 1);
            end
            prev = done_cyc;
        end
    endtask

    task automatic test_ignore_busy();
        start_txn(1'b0, 5'd2, '0);
        req = 1'b1; wr = 1'b1; addr = 5'd7; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        addr = 5'd8;
        @(negedge clk);
        req = 1'b0;
        wait_done("ign_rd2");
        check_rdata("ign_rd2", 32'd6);
        start_txn(1'b0, 5'd7, '0);
        wait_done("ign_rd7");
        check_rdata("ign_rd7", 32'd21);
        start_txn(1'b0, 5'd8, '0);
        wait_done("ign_rd8");
        check_rdata("ign_rd8", 32'd24);
    endtask

    task automatic test_abort();
        int seen = 0;
        start_txn(1'b1, 5'd9, 32'hAAAA5555);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL abort_reset_state: ready=%b busy=%b done=%b rdata=%h, expected 1 0 0 0",
                     ready, busy, done, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d done pulses, expected 0", seen);
        end
        start_txn(1'b0, 5'd9, '0);
        wait_done("abort_rd9");
        check_rdata("abort_rd9", 32'd27);
    endtask

`ifdef MEM_BACKEND_STATS_EN
    task automatic test_stats();
        start_txn(1'b0, 5'd1, '0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_txn(1'b1, 5'd20, 32'h1); wait_done("st_wr");
        start_txn(1'b1, 5'd21, 32'h2); wait_done("st_wr");
        start_txn(1'b1, 5'd22, 32'h3); wait_done("st_wr");
        start_txn(1'b0, 5'd20, '0);    wait_done("st_rd");
        start_txn(1'b0, 5'd22, '0);    wait_done("st_rd");
        check_rdata("st_rd22", 32'h3);
        checks++;
        if (wr_cnt !== 16'd3 || rd_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stats_counts: wr_cnt=%0d rd_cnt=%0d, expected 3 2", wr_cnt, rd_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset: wr_cnt=%0d rd_cnt=%0d, expected 0 0", wr_cnt, rd_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_busy();
        test_abort();
`ifdef MEM_BACKEND_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
